// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch port: one-outstanding request/grant plus read-data return.
// master = fetch controller, slave = instruction memory.
interface pc_fetch_ctrl_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC owner and next-PC mux sequencer with a single outstanding imem fetch.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect target traps).
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// FETCH | request held at fetch_pc until granted
// WAIT  | granted, waiting for read data
// HOLD  | instruction presented until decode consumes it
// TRAP  | misaligned redirect seen, fetching halted until reset (macro only)
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    pc_fetch_ctrl_if.master       imem,
    input  logic [31:0]           next_pc_i,
    output logic [1:0]            nextpcsel_o,
    input  logic                  branch_taken_i,
    input  logic                  jal_i,
    input  logic                  jalr_i,
    input  logic                  stall_i,
    output logic [31:0]           instr_o,
    output logic [31:0]           pc_o,
    output logic                  instr_valid_o
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3
`ifdef PC_MISALIGN_TRAP_EN
        ,
        S_TRAP  = 3'd4
`endif
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] fetch_pc;
    logic        req;
    logic        consume;
    logic        trap_hit;

    assign consume          = instr_valid_o & ~stall_i;
    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = fetch_pc;

`ifdef PC_MISALIGN_TRAP_EN
    assign trap_hit = consume & (nextpcsel_o != 2'b00) & (next_pc_i[1:0] != 2'b00);
`else
    assign trap_hit = 1'b0;
`endif

    // Redirect inputs only matter in the consume cycle; jalr > jal > branch.
    always_comb begin
        nextpcsel_o = 2'b00;
        if (consume) begin
            if (jalr_i)
                nextpcsel_o = 2'b11;
            else if (jal_i)
                nextpcsel_o = 2'b10;
            else if (branch_taken_i)
                nextpcsel_o = 2'b01;
            else
                nextpcsel_o = 2'b00;
        end
    end

    always_comb begin
        state_nx = state;
        req      = 1'b0;
        case (state)
            S_IDLE: begin
                state_nx = S_FETCH;
            end
            S_FETCH: begin
                req = 1'b1;
                if (imem.imem_gnt_i)
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (imem.imem_rvalid_i)
                    state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (consume) begin
`ifdef PC_MISALIGN_TRAP_EN
                    state_nx = trap_hit ? S_TRAP : S_FETCH;
`else
                    state_nx = S_FETCH;
`endif
                end
            end
`ifdef PC_MISALIGN_TRAP_EN
            S_TRAP: begin
                state_nx = S_TRAP;
            end
`endif
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Read data is accepted only in WAIT, so a response still in flight across reset is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc      <= RESET_PC;
            instr_o       <= 32'h0000_0000;
            pc_o          <= 32'h0000_0000;
            instr_valid_o <= 1'b0;
        end else begin
            if (state == S_WAIT && imem.imem_rvalid_i) begin
                instr_o       <= imem.imem_rdata_i;
                pc_o          <= fetch_pc;
                instr_valid_o <= 1'b1;
            end else if (state == S_HOLD && consume) begin
                fetch_pc      <= next_pc_i;
                instr_valid_o <= 1'b0;
            end
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            misalign_o <= 1'b0;
        else if (state == S_HOLD && trap_hit)
            misalign_o <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl: a transaction-level imem/decode model
// predicts fetch addresses, presented instructions and mux selects.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc_i;
    logic [1:0]  nextpcsel_o;
    logic        branch_taken_i;
    logic        jal_i;
    logic        jalr_i;
    logic        stall_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pc_fetch_ctrl_if imem ();

    pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (imem),
        .next_pc_i      (next_pc_i),
        .nextpcsel_o    (nextpcsel_o),
        .branch_taken_i (branch_taken_i),
        .jal_i          (jal_i),
        .jalr_i         (jalr_i),
        .stall_i        (stall_i),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .instr_valid_o  (instr_valid_o)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misalign_o     (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Mux select from the redirect flags {jalr, jal, branch}.
    function automatic logic [1:0] sel_model(input logic [2:0] fl);
        if (fl[2])      return 2'd3;
        else if (fl[1]) return 2'd2;
        else if (fl[0]) return 2'd1;
        else            return 2'd0;
    endfunction

    task automatic noise();
        branch_taken_i = 1'($urandom_range(0, 1));
        jal_i          = 1'($urandom_range(0, 1));
        jalr_i         = 1'($urandom_range(0, 1));
        stall_i        = 1'($urandom_range(0, 1));
        next_pc_i      = $urandom;
    endtask

    task automatic check_reset_vals();
        check_eq("rst_req",   imem.imem_req_o, 0);
        check_eq("rst_addr",  imem.imem_addr_o, RST_PC);
        check_eq("rst_valid", instr_valid_o, 0);
        check_eq("rst_instr", instr_o, 0);
        check_eq("rst_pc",    pc_o, 0);
        check_eq("rst_sel",   nextpcsel_o, 0);
`ifdef PC_MISALIGN_TRAP_EN
        check_eq("rst_misalign", misalign_o, 0);
`endif
    endtask

    // One full fetch/present/consume transaction; called at a negedge, returns at a negedge.
    task automatic txn(input logic [31:0] exp_addr, input int d, input int r, input int s,
                       input logic [31:0] data, input logic [2:0] fl, input logic [31:0] np,
                       input bit exp_trap);
        int k;
        k = 0;
        while (!imem.imem_req_o && k < 8) begin
            noise();
            imem.imem_gnt_i = 1'b0;
            imem.imem_rvalid_i = 1'b0;
            @(negedge clk);
            k++;
        end
        check_eq("req_seen", imem.imem_req_o, 1);
        check_eq("req_addr", imem.imem_addr_o, exp_addr);
        repeat (d) begin
            noise();
            imem.imem_gnt_i    = 1'b0;
            imem.imem_rvalid_i = 1'($urandom_range(0, 1));
            imem.imem_rdata_i  = $urandom;
            #1 check_eq("sel_fetch", nextpcsel_o, 0);
            @(negedge clk);
            check_eq("req_hold",    imem.imem_req_o, 1);
            check_eq("addr_hold",   imem.imem_addr_o, exp_addr);
            check_eq("valid_fetch", instr_valid_o, 0);
        end
        noise();
        imem.imem_gnt_i    = 1'b1;
        imem.imem_rvalid_i = 1'($urandom_range(0, 1));
        imem.imem_rdata_i  = $urandom;
        @(negedge clk);
        imem.imem_gnt_i    = 1'b0;
        imem.imem_rvalid_i = 1'b0;
        check_eq("req_wait",   imem.imem_req_o, 0);
        check_eq("valid_wait", instr_valid_o, 0);
        repeat (r) begin
            noise();
            @(negedge clk);
            check_eq("req_wait",   imem.imem_req_o, 0);
            check_eq("valid_wait", instr_valid_o, 0);
        end
        noise();
        imem.imem_rvalid_i = 1'b1;
        imem.imem_rdata_i  = data;
        @(negedge clk);
        imem.imem_rvalid_i = 1'b0;
        check_eq("valid_hold", instr_valid_o, 1);
        check_eq("instr",      instr_o, data);
        check_eq("pc",         pc_o, exp_addr);
        check_eq("req_hold_0", imem.imem_req_o, 0);
        repeat (s) begin
            noise();
            stall_i            = 1'b1;
            imem.imem_rvalid_i = 1'($urandom_range(0, 1));
            imem.imem_rdata_i  = $urandom;
            #1 check_eq("sel_stall", nextpcsel_o, 0);
            @(negedge clk);
            check_eq("instr_stall", instr_o, data);
            check_eq("pc_stall",    pc_o, exp_addr);
            check_eq("valid_stall", instr_valid_o, 1);
            check_eq("req_stall",   imem.imem_req_o, 0);
        end
        imem.imem_rvalid_i = 1'b0;
        stall_i = 1'b0;
        {jalr_i, jal_i, branch_taken_i} = fl;
        next_pc_i = np;
        #1 check_eq("sel_consume", nextpcsel_o, sel_model(fl));
        @(negedge clk);
        {jalr_i, jal_i, branch_taken_i} = 3'b000;
        check_eq("valid_after", instr_valid_o, 0);
        if (exp_trap) begin
            check_eq("req_trap", imem.imem_req_o, 0);
`ifdef PC_MISALIGN_TRAP_EN
            check_eq("misalign_set", misalign_o, 1);
`endif
        end else begin
            check_eq("req_next",  imem.imem_req_o, 1);
            check_eq("addr_next", imem.imem_addr_o, np);
`ifdef PC_MISALIGN_TRAP_EN
            check_eq("misalign_clr", misalign_o, 0);
`endif
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp;
        logic [31:0] np;
        logic [2:0]  fl;
        int          k;

        reset = 1'b1;
        next_pc_i = 0; branch_taken_i = 0; jal_i = 0; jalr_i = 0; stall_i = 0;
        imem.imem_gnt_i = 0; imem.imem_rvalid_i = 0; imem.imem_rdata_i = 0;
        #12 check_reset_vals();
        @(negedge clk);
        reset = 1'b0;
        #1 check_eq("idle_req", imem.imem_req_o, 0);
        @(negedge clk);

        txn(32'h0, 0, 0, 0, 32'h0000_0013, 3'b000, 32'h4, 0);
        txn(32'h4, 0, 0, 5, $urandom, 3'b000, 32'h8, 0);
        txn(32'h8, 0, 0, 0, $urandom, 3'b011, 32'h100, 0);
        txn(32'h100, 1, 0, 0, $urandom, 3'b110, 32'h2000, 0);
        txn(32'h2000, 4, 1, 0, $urandom, 3'b100, 32'hFFFF_FFFC, 0);
        txn(32'hFFFF_FFFC, 0, 0, 0, $urandom, 3'b000, 32'h0, 0);
        exp = 32'h0;
`ifndef PC_MISALIGN_TRAP_EN
        txn(exp, 0, 0, 0, $urandom, 3'b100, 32'h102, 0);
        txn(32'h102, 0, 0, 0, $urandom, 3'b000, 32'h106, 0);
        exp = 32'h106;
`endif

        for (int i = 0; i < 40; i++) begin
            fl = 3'($urandom_range(0, 7));
            if (fl == 3'b000) np = exp + 32'd4;
            else              np = $urandom;
`ifdef PC_MISALIGN_TRAP_EN
            np[1:0] = 2'b00;
`else
            if ($urandom_range(0, 3) != 0) np[1:0] = 2'b00;
`endif
            txn(exp, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom, fl, np, 0);
            exp = np;
        end

        // Reset while waiting for read data; the late response must be dropped.
        k = 0;
        while (!imem.imem_req_o && k < 8) begin
            @(negedge clk);
            k++;
        end
        check_eq("req_pre_rst", imem.imem_req_o, 1);
        imem.imem_gnt_i = 1'b1;
        @(negedge clk);
        imem.imem_gnt_i = 1'b0;
        #2 reset = 1'b1;
        imem.imem_rvalid_i = 1'b1;
        imem.imem_rdata_i  = 32'hDEAD_BEEF;
        #1 check_reset_vals();
        @(negedge clk);
        reset = 1'b0;
        #1 check_eq("idle_req2", imem.imem_req_o, 0);
        @(negedge clk);
        imem.imem_rvalid_i = 1'b0;
        check_eq("stale_valid", instr_valid_o, 0);
        check_eq("req_after_rst", imem.imem_req_o, 1);
        check_eq("addr_after_rst", imem.imem_addr_o, RST_PC);
        @(negedge clk);
        check_eq("stale_valid2", instr_valid_o, 0);
        txn(RST_PC, 0, 0, 1, 32'h1234_5678, 3'b001, 32'h40, 0);

`ifdef PC_MISALIGN_TRAP_EN
        txn(32'h40, 0, 0, 0, $urandom, 3'b100, 32'h102, 1);
        repeat (5) begin
            noise();
            imem.imem_gnt_i = 1'b1;
            imem.imem_rvalid_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("trap_req",      imem.imem_req_o, 0);
            check_eq("trap_valid",    instr_valid_o, 0);
            check_eq("trap_misalign", misalign_o, 1);
            check_eq("trap_addr",     imem.imem_addr_o, 32'h102);
        end
        imem.imem_gnt_i = 1'b0;
        imem.imem_rvalid_i = 1'b0;
        #1 reset = 1'b1;
        #1 check_reset_vals();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("req_post_trap", imem.imem_req_o, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
